// File: rtl/axi_arbiter_w.sv
// Write-path arbiter: two AXI4 masters share one slave AW/W/B bus, owned per whole
// write transaction (AW, W burst to WLAST, B), round-robin on ties, optional watchdog.
module axi_arbiter_w #(
  parameter int TCO     = 1,
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 16
) (
  input  logic ACLK,
  input  logic ARESETn,
  input  logic m0_AWVALID,
  input  logic m1_AWVALID,
  input  logic s_AWVALID,
  input  logic s_AWREADY,
  input  logic s_WVALID,
  input  logic s_WREADY,
  input  logic s_WLAST,
  input  logic s_BVALID,
  input  logic s_BREADY,
  output logic m0_wgrnt,
  output logic m1_wgrnt,
  output logic wr_busy,
  output logic wr_timeout
);

  // TCO is a delay hook for behavioural models only; the RTL itself carries no delays.
  if (TCO < 0 || TIMEOUT < 0 || longint'(TIMEOUT) >= (longint'(1) << CNT_W)) begin : g_bad_param
    $error("axi_arbiter_w: TCO/TIMEOUT/CNT_W out of range");
  end

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t           state;
  logic             owner;
  logic             last_owner;
  logic             w_done;
  logic [CNT_W-1:0] cnt;

  logic aw_hs, w_hs, wl_hs, b_hs;
  logic pick;
  logic wd_en, wd_fire;

  assign aw_hs = s_AWVALID & s_AWREADY;
  assign w_hs  = s_WVALID & s_WREADY;
  assign wl_hs = w_hs & s_WLAST;
  assign b_hs  = s_BVALID & s_BREADY;

  // A lone requester wins outright; on a tie the master that did not own the bus last wins.
  assign pick = (m0_AWVALID && m1_AWVALID) ? ~last_owner : m1_AWVALID;

  assign wd_en   = (TIMEOUT != 0);
  assign wd_fire = wd_en && (state == DATA || state == RESP) && !w_hs && !b_hs
                   && (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      w_done     <= 1'b0;
      cnt        <= '0;
      m0_wgrnt   <= 1'b0;
      m1_wgrnt   <= 1'b0;
      wr_busy    <= 1'b0;
      wr_timeout <= 1'b0;
    end else begin
      wr_timeout <= 1'b0;
      case (state)
        IDLE: begin
          cnt    <= '0;
          w_done <= 1'b0;
          if (m0_AWVALID || m1_AWVALID) begin
            owner    <= pick;
            state    <= ADDR;
            m0_wgrnt <= ~pick;
            m1_wgrnt <= pick;
            wr_busy  <= 1'b1;
          end
        end

        ADDR: begin
          if (aw_hs) begin
            state  <= (w_done || wl_hs) ? RESP : DATA;
            w_done <= 1'b0;
            cnt    <= '0;
          end else if (wl_hs) begin
            w_done <= 1'b1;
          end
        end

        DATA: begin
          if (wd_fire) begin
            state      <= IDLE;
            m0_wgrnt   <= 1'b0;
            m1_wgrnt   <= 1'b0;
            wr_busy    <= 1'b0;
            wr_timeout <= 1'b1;
            last_owner <= owner;
            w_done     <= 1'b0;
            cnt        <= '0;
          end else if (wl_hs) begin
            state <= RESP;
            cnt   <= '0;
          end else if (w_hs || b_hs) begin
            cnt <= '0;
          end else if (wd_en) begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        RESP: begin
          if (b_hs || wd_fire) begin
            state      <= IDLE;
            m0_wgrnt   <= 1'b0;
            m1_wgrnt   <= 1'b0;
            wr_busy    <= 1'b0;
            wr_timeout <= wd_fire;
            last_owner <= owner;
            w_done     <= 1'b0;
            cnt        <= '0;
          end else if (w_hs) begin
            cnt <= '0;
          end else if (wd_en) begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state    <= IDLE;
          m0_wgrnt <= 1'b0;
          m1_wgrnt <= 1'b0;
          wr_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_arbiter_w.sv
// Directed bench for axi_arbiter_w with an 8-cycle watchdog.
module tb_axi_arbiter_w;

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  logic m0_AWVALID = 1'b0, m1_AWVALID = 1'b0;
  logic s_AWVALID = 1'b0, s_AWREADY = 1'b0;
  logic s_WVALID = 1'b0, s_WREADY = 1'b0, s_WLAST = 1'b0;
  logic s_BVALID = 1'b0, s_BREADY = 1'b0;
  logic m0_wgrnt, m1_wgrnt, wr_busy, wr_timeout;

  int n_pass = 0;
  int n_chk  = 0;

  axi_arbiter_w #(.TCO(1), .TIMEOUT(8), .CNT_W(16)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .m0_AWVALID(m0_AWVALID), .m1_AWVALID(m1_AWVALID),
    .s_AWVALID(s_AWVALID), .s_AWREADY(s_AWREADY),
    .s_WVALID(s_WVALID), .s_WREADY(s_WREADY), .s_WLAST(s_WLAST),
    .s_BVALID(s_BVALID), .s_BREADY(s_BREADY),
    .m0_wgrnt(m0_wgrnt), .m1_wgrnt(m1_wgrnt),
    .wr_busy(wr_busy), .wr_timeout(wr_timeout)
  );

  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic clear_inputs();
    m0_AWVALID = 0; m1_AWVALID = 0;
    s_AWVALID = 0; s_AWREADY = 0;
    s_WVALID = 0; s_WREADY = 0; s_WLAST = 0;
    s_BVALID = 0; s_BREADY = 0;
  endtask

  task automatic do_reset();
    ARESETn = 0;
    clear_inputs();
    tick();
    tick();
    ARESETn = 1;
  endtask

  task automatic test_reset();
    ARESETn = 0;
    clear_inputs();
    tick();
    tick();
    n_chk++;
    if ({m1_wgrnt, m0_wgrnt, wr_busy, wr_timeout} !== 4'b0000)
      $display("FAIL reset_outputs: got %b expected 0000", {m1_wgrnt, m0_wgrnt, wr_busy, wr_timeout});
    else n_pass++;
    ARESETn = 1;
  endtask

  task automatic test_single_burst();
    do_reset();
    tick();
    tick();
    m0_AWVALID = 1;
    tick();
    n_chk++;
    if ({m1_wgrnt, m0_wgrnt, wr_busy} !== 3'b011)
      $display("FAIL single_grant: got %b expected 011", {m1_wgrnt, m0_wgrnt, wr_busy});
    else n_pass++;
    m0_AWVALID = 0; s_AWVALID = 1; s_AWREADY = 1;
    tick();
    s_AWVALID = 0; s_AWREADY = 0;
    s_WVALID = 1; s_WREADY = 1;
    for (int b = 0; b < 4; b++) begin
      s_WLAST = (b == 3);
      tick();
    end
    s_WVALID = 0; s_WREADY = 0; s_WLAST = 0;
    tick();
    n_chk++;
    if ({m1_wgrnt, m0_wgrnt, wr_busy} !== 3'b011)
      $display("FAIL single_hold_resp: got %b expected 011", {m1_wgrnt, m0_wgrnt, wr_busy});
    else n_pass++;
    s_BVALID = 1; s_BREADY = 1;
    tick();
    s_BVALID = 0; s_BREADY = 0;
    n_chk++;
    if ({m1_wgrnt, m0_wgrnt, wr_busy} !== 3'b000)
      $display("FAIL single_release: got %b expected 000", {m1_wgrnt, m0_wgrnt, wr_busy});
    else n_pass++;
    n_chk++;
    if (dut.last_owner !== 1'b0)
      $display("FAIL single_last_owner: got %b expected 0", dut.last_owner);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g;
    do_reset();
    m0_AWVALID = 1; m1_AWVALID = 1;
    for (int t = 0; t < 4; t++) begin
      exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
      tick();
      n_chk++;
      if ({m1_wgrnt, m0_wgrnt} !== exp_g)
        $display("FAIL rr_grant_%0d: got %b expected %b", t, {m1_wgrnt, m0_wgrnt}, exp_g);
      else n_pass++;
      s_AWVALID = 1; s_AWREADY = 1; s_WVALID = 1; s_WREADY = 1; s_WLAST = 1;
      tick();
      s_AWVALID = 0; s_AWREADY = 0; s_WVALID = 0; s_WREADY = 0; s_WLAST = 0;
      s_BVALID = 1; s_BREADY = 1;
      tick();
      s_BVALID = 0; s_BREADY = 0;
      n_chk++;
      if ({m1_wgrnt, m0_wgrnt, wr_busy} !== 3'b000)
        $display("FAIL rr_bubble_%0d: got %b expected 000", t, {m1_wgrnt, m0_wgrnt, wr_busy});
      else n_pass++;
    end
    clear_inputs();
  endtask

  task automatic test_w_before_aw();
    do_reset();
    m1_AWVALID = 1;
    tick();
    n_chk++;
    if ({m1_wgrnt, m0_wgrnt} !== 2'b10)
      $display("FAIL wfirst_grant: got %b expected 10", {m1_wgrnt, m0_wgrnt});
    else n_pass++;
    s_AWVALID = 1;
    s_WVALID = 1; s_WREADY = 1; s_WLAST = 1;
    tick();
    s_WVALID = 0; s_WREADY = 0; s_WLAST = 0;
    tick();
    s_AWREADY = 1;
    tick();
    m1_AWVALID = 0; s_AWVALID = 0; s_AWREADY = 0;
    n_chk++;
    if ({m1_wgrnt, m0_wgrnt, wr_busy} !== 3'b101)
      $display("FAIL wfirst_after_aw: got %b expected 101", {m1_wgrnt, m0_wgrnt, wr_busy});
    else n_pass++;
    s_BVALID = 1; s_BREADY = 1;
    tick();
    s_BVALID = 0; s_BREADY = 0;
    n_chk++;
    if ({m1_wgrnt, m0_wgrnt, wr_busy} !== 3'b000)
      $display("FAIL wfirst_release: got %b expected 000", {m1_wgrnt, m0_wgrnt, wr_busy});
    else n_pass++;
  endtask

  task automatic test_timeout();
    int pulses;
    do_reset();
    m0_AWVALID = 1;
    tick();
    m0_AWVALID = 0; m1_AWVALID = 1;
    s_AWVALID = 1; s_AWREADY = 1;
    tick();
    s_AWVALID = 0; s_AWREADY = 0;
    pulses = 0;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (wr_timeout) pulses++;
    end
    n_chk++;
    if ({m1_wgrnt, m0_wgrnt, wr_timeout} !== 3'b010)
      $display("FAIL to_before: got %b expected 010", {m1_wgrnt, m0_wgrnt, wr_timeout});
    else n_pass++;
    tick();
    if (wr_timeout) pulses++;
    n_chk++;
    if ({m1_wgrnt, m0_wgrnt, wr_timeout} !== 3'b001)
      $display("FAIL to_fire: got %b expected 001", {m1_wgrnt, m0_wgrnt, wr_timeout});
    else n_pass++;
    tick();
    if (wr_timeout) pulses++;
    n_chk++;
    if ({m1_wgrnt, m0_wgrnt, wr_timeout} !== 3'b100)
      $display("FAIL to_next_grant: got %b expected 100", {m1_wgrnt, m0_wgrnt, wr_timeout});
    else n_pass++;
    n_chk++;
    if (pulses !== 1)
      $display("FAIL to_pulse_count: got %0d expected 1", pulses);
    else n_pass++;
    m1_AWVALID = 0;
    s_AWVALID = 1; s_AWREADY = 1; s_WVALID = 1; s_WREADY = 1; s_WLAST = 1;
    tick();
    clear_inputs();
    s_BVALID = 1; s_BREADY = 1;
    tick();
    clear_inputs();
  endtask

  task automatic test_no_timeout();
    int pulses;
    do_reset();
    m0_AWVALID = 1;
    tick();
    m0_AWVALID = 0;
    s_AWVALID = 1; s_AWREADY = 1;
    tick();
    s_AWVALID = 0; s_AWREADY = 0;
    pulses = 0;
    for (int b = 0; b < 5; b++) begin
      for (int g = 0; g < 6; g++) begin
        tick();
        if (wr_timeout) pulses++;
      end
      s_WVALID = 1; s_WREADY = 1; s_WLAST = (b == 4);
      tick();
      if (wr_timeout) pulses++;
      s_WVALID = 0; s_WREADY = 0; s_WLAST = 0;
    end
    n_chk++;
    if (pulses !== 0 || {m1_wgrnt, m0_wgrnt} !== 2'b01)
      $display("FAIL nto_beats: got pulses=%0d grant=%b expected pulses=0 grant=01", pulses, {m1_wgrnt, m0_wgrnt});
    else n_pass++;
    for (int c = 0; c < 7; c++) begin
      tick();
      if (wr_timeout) pulses++;
    end
    n_chk++;
    if (pulses !== 0 || {m1_wgrnt, m0_wgrnt} !== 2'b01)
      $display("FAIL nto_resp_wait: got pulses=%0d grant=%b expected pulses=0 grant=01", pulses, {m1_wgrnt, m0_wgrnt});
    else n_pass++;
    s_BVALID = 1; s_BREADY = 1;
    tick();
    s_BVALID = 0; s_BREADY = 0;
    n_chk++;
    if ({m1_wgrnt, m0_wgrnt, wr_timeout} !== 3'b000)
      $display("FAIL nto_b_priority: got %b expected 000", {m1_wgrnt, m0_wgrnt, wr_timeout});
    else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    m1_AWVALID = 1;
    tick();
    m1_AWVALID = 0;
    s_AWVALID = 1; s_AWREADY = 1;
    tick();
    s_AWVALID = 0; s_AWREADY = 0;
    n_chk++;
    if ({m1_wgrnt, m0_wgrnt} !== 2'b10)
      $display("FAIL ar_in_data: got %b expected 10", {m1_wgrnt, m0_wgrnt});
    else n_pass++;
    #2;
    ARESETn = 0;
    #1;
    n_chk++;
    if ({m1_wgrnt, m0_wgrnt, wr_busy} !== 3'b000)
      $display("FAIL ar_async_drop: got %b expected 000", {m1_wgrnt, m0_wgrnt, wr_busy});
    else n_pass++;
    m0_AWVALID = 1; m1_AWVALID = 1;
    tick();
    ARESETn = 1;
    tick();
    n_chk++;
    if ({m1_wgrnt, m0_wgrnt} !== 2'b01)
      $display("FAIL ar_first_tie: got %b expected 01", {m1_wgrnt, m0_wgrnt});
    else n_pass++;
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_w_before_aw();
    test_timeout();
    test_no_timeout();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
